snina_fault_response: RTL and testbench
=======================================

Name: snina_fault_response

Overview:
- Downstream stage of the d2_k2 SNI-NA multiplier (andSNINA). Consumes its three 3-bit output share codewords and its three per-share check flags.
- Releases each result beat through a 1-entry valid/ready output register, but only if all three share checks passed.
- On a failed check it blocks the beat, zeroes all output shares and raises a sticky alarm.
- Counts faults; after a threshold it locks permanently until reset.

Parameters:
- CNT_W, 8, width of the saturating fault counter.
- LOCK_THRESH, 4, fault count at which the block enters LOCKED. Legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  a multiplier result beat is present this cycle.
- in_ready  output  1  the output register can take a beat.
- port_c_0  input  3  share 0 codeword.
- port_c_1  input  3  share 1 codeword.
- port_c_2  input  3  share 2 codeword.
- port_errorFlag_0  input  1  share-0 check result; 1 = consistent (pass), 0 = fault.
- port_errorFlag_1  input  1  share-1 check result, same encoding.
- port_errorFlag_2  input  1  share-2 check result, same encoding.
- clear_alarm  input  1  single-cycle request to leave ALARM.
- out_ready  input  1  consumer accepts out beat.
- out_valid  output  1  out beat present.
- port_q_0  output  3  released share 0.
- port_q_1  output  3  released share 1.
- port_q_2  output  3  released share 2.
- alarm  output  1  high in ALARM or LOCKED.
- locked  output  1  high in LOCKED.
- overflow  output  1  sticky; set when a beat was dropped.
- fault_cnt  output  CNT_W  saturating count of faulty beats.

Behaviour:
- Reset (reset=0, asynchronous): state=RUN. out_valid, port_q_0..2, alarm, locked, overflow and fault_cnt all go to 0.
- Definitions:
  - fault = in_valid & ~(port_errorFlag_0 & port_errorFlag_1 & port_errorFlag_2).
  - in_ready = (state==RUN) ? (~out_valid | out_ready) : 1.
- Flags and shares arrive aligned in the same cycle. The block performs no re-alignment.
- Share domains stay separated:
  - each port_q_i is a registered copy of port_c_i only;
  - no XOR or mixing across shares;
  - no per-bit gating that depends on another share's data.
- RUN state:
  - Clean accepted beat (in_valid & in_ready & ~fault): next cycle port_q_i=port_c_i and out_valid=1. Latency is 1 cycle.
  - out_valid&out_ready with no new accept: out_valid clears; port_q holds its value.
  - Simultaneous pop and push: the new beat replaces the old one, giving full throughput.
  - Faulty beat (in_valid & fault, regardless of in_ready):
    - state goes to ALARM;
    - out_valid goes to 0 and any pending beat is discarded;
    - port_q_0..2 go to 0;
    - the faulty beat is never presented.
  - in_valid & ~in_ready & ~fault: the beat is dropped and overflow goes to 1 (sticky until reset). The upstream multiplier has no backpressure.
- ALARM state:
  - alarm=1, out_valid=0, port_q=0. All beats are drained (in_ready=1) and discarded.
  - clear_alarm=1 with no fault in the same cycle goes to RUN.
  - clear_alarm together with a fault stays in ALARM; the fault is counted.
- LOCKED state:
  - alarm=1, locked=1, out_valid=0, port_q=0. clear_alarm is ignored.
  - Exit is by reset only.
- Fault counter:
  - Increments on every cycle with fault=1 in any state.
  - Saturates at 2^CNT_W-1 and never wraps.
  - When the post-increment value reaches LOCK_THRESH, the next state is LOCKED. This overrides both the RUN→ALARM transition and clear_alarm.
- clear_alarm in RUN or LOCKED has no effect.
- Reset asserted mid-beat: everything returns to the reset values asynchronously. The in-flight beat is lost.

Test Plan:
- Clean stream: in_valid=1 and all flags=1 for 3 cycles with port_c_0..2 = 3'b111/3'b000/3'b111, out_ready=1 → out_valid from cycle+1, port_q values match, alarm=0, fault_cnt=0.
- Single fault: port_errorFlag_1=0 on beat 2 → out_valid=0 and port_q=0 the next cycle, alarm=1, fault_cnt=1. Beats 3+ are not released. Then clear_alarm=1 → RUN, and the next clean beat is released after 1 cycle.
- Clear colliding with fault: in ALARM, clear_alarm=1 with a fault in the same cycle → stay ALARM, fault_cnt increments.
- Lockout: 4 faults separated by clear_alarm → after the 4th fault locked=1. Later clear_alarm has no effect; only reset (reset=0) returns to RUN with fault_cnt=0.
- Backpressure: out_ready=0 while out_valid=1 and a new clean beat arrives → overflow=1, port_q keeps the first beat. Raising out_ready then pops it.
- Async reset: pull reset low mid-cycle while out_valid=1 → all outputs are 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/snina_fault_response.sv
// Fault-response stage behind the SNI-NA multiplier.
// Clean beats go to a 1-entry valid/ready register. Faulty beats
// zero the output shares and raise the alarm. Enough faults lock the
// block until reset.
//
// state  | meaning
// RUN    | normal forwarding through the output register
// ALARM  | fault seen; beats are drained and discarded until clear_alarm
// LOCKED | fault threshold reached; only reset leaves this state
module snina_fault_response #(
  parameter int CNT_W       = 8,
  parameter int LOCK_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       port_c_0,
  input  logic [2:0]       port_c_1,
  input  logic [2:0]       port_c_2,
  input  logic             port_errorFlag_0,
  input  logic             port_errorFlag_1,
  input  logic             port_errorFlag_2,
  input  logic             clear_alarm,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [2:0]       port_q_0,
  output logic [2:0]       port_q_1,
  output logic [2:0]       port_q_2,
  output logic             alarm,
  output logic             locked,
  output logic             overflow,
  output logic [CNT_W-1:0] fault_cnt
);

  typedef enum logic [1:0] {RUN, ALARM, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(LOCK_THRESH);

  state_t           state, state_nxt;
  logic             fault;
  logic             accept;
  logic             lock_hit;
  logic [CNT_W-1:0] cnt_nxt;

  // Fault detection, handshake and saturating count are pure functions of inputs and state.
  always_comb begin
    fault    = in_valid & ~(port_errorFlag_0 & port_errorFlag_1 & port_errorFlag_2);
    in_ready = (state == RUN) ? (~out_valid | out_ready) : 1'b1;
    accept   = (state == RUN) & in_valid & in_ready & ~fault;
    cnt_nxt  = (fault && (fault_cnt != CNT_MAX)) ? fault_cnt + 1'b1 : fault_cnt;
    // Once the post-increment count reaches the threshold we lock; this
    // wins over both the alarm transition and a simultaneous clear.
    lock_hit = fault & (cnt_nxt >= THRESH);
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (lock_hit)   state_nxt = LOCKED;
        else if (fault) state_nxt = ALARM;
      end
      ALARM: begin
        if (lock_hit)                 state_nxt = LOCKED;
        else if (clear_alarm & ~fault) state_nxt = RUN;
      end
      LOCKED: state_nxt = LOCKED;
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Output register, sticky overflow and fault counter. Each port_q_i only
  // ever loads its own port_c_i or zero, keeping the share domains apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      port_q_0  <= 3'd0;
      port_q_1  <= 3'd0;
      port_q_2  <= 3'd0;
      overflow  <= 1'b0;
      fault_cnt <= '0;
    end else begin
      fault_cnt <= cnt_nxt;
      if (in_valid & ~in_ready & ~fault) overflow <= 1'b1;
      if ((state != RUN) || fault) begin
        out_valid <= 1'b0;
        port_q_0  <= 3'd0;
        port_q_1  <= 3'd0;
        port_q_2  <= 3'd0;
      end else if (accept) begin
        out_valid <= 1'b1;
        port_q_0  <= port_c_0;
        port_q_1  <= port_c_1;
        port_q_2  <= port_c_2;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign alarm  = (state != RUN);
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_snina_fault_response.sv
// Self-checking bench for snina_fault_response: directed scenarios with
// literal expectations, then a randomized run against a behavioural model.
module tb_snina_fault_response;

  localparam int CNT_W = 8;
  localparam int LOCK_THRESH = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0] port_c_0 = '0, port_c_1 = '0, port_c_2 = '0;
  logic port_errorFlag_0 = 1'b1, port_errorFlag_1 = 1'b1, port_errorFlag_2 = 1'b1;
  logic clear_alarm = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [2:0] port_q_0, port_q_1, port_q_2;
  logic alarm, locked, overflow;
  logic [CNT_W-1:0] fault_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Behavioural model: mode 0 = forwarding, 1 = alarmed, 2 = locked out.
  int m_mode = 0;
  bit m_valid = 0;
  int m_q[3] = '{0, 0, 0};
  bit m_ovf = 0;
  int m_cnt = 0;

  snina_fault_response #(.CNT_W(CNT_W), .LOCK_THRESH(LOCK_THRESH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .port_c_0(port_c_0), .port_c_1(port_c_1), .port_c_2(port_c_2),
    .port_errorFlag_0(port_errorFlag_0), .port_errorFlag_1(port_errorFlag_1),
    .port_errorFlag_2(port_errorFlag_2), .clear_alarm(clear_alarm),
    .out_ready(out_ready), .out_valid(out_valid),
    .port_q_0(port_q_0), .port_q_1(port_q_1), .port_q_2(port_q_2),
    .alarm(alarm), .locked(locked), .overflow(overflow), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_fault();
    return in_valid && !(port_errorFlag_0 && port_errorFlag_1 && port_errorFlag_2);
  endfunction

  function automatic bit m_ready();
    return (m_mode == 0) ? (!m_valid || out_ready) : 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_valid = 0; m_q = '{0, 0, 0}; m_ovf = 0; m_cnt = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    bit f, rdy;
    int cnt_new;
    f = m_fault();
    rdy = m_ready();
    cnt_new = f ? ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX) : m_cnt;
    if (m_mode == 0) begin
      if (f) begin
        m_valid = 0; m_q = '{0, 0, 0};
        m_mode = (cnt_new >= LOCK_THRESH) ? 2 : 1;
      end else begin
        if (in_valid && rdy) begin
          m_valid = 1;
          m_q = '{int'(port_c_0), int'(port_c_1), int'(port_c_2)};
        end else if (m_valid && out_ready) begin
          m_valid = 0;
        end
        if (in_valid && !rdy) m_ovf = 1;
      end
    end else if (m_mode == 1) begin
      if (f && cnt_new >= LOCK_THRESH) m_mode = 2;
      else if (clear_alarm && !f) m_mode = 0;
    end
    m_cnt = cnt_new;
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("port_q_0", 32'(port_q_0), m_q[0]);
      chk("port_q_1", 32'(port_q_1), m_q[1]);
      chk("port_q_2", 32'(port_q_2), m_q[2]);
      chk("alarm", 32'(alarm), 32'(m_mode != 0));
      chk("locked", 32'(locked), 32'(m_mode == 2));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("fault_cnt", 32'(fault_cnt), m_cnt);
    end
  end

  task automatic drive(input bit iv, input int c0, input int c1, input int c2,
                       input bit f0, input bit f1, input bit f2,
                       input bit clr, input bit ordy);
    in_valid = iv;
    port_c_0 = 3'(c0); port_c_1 = 3'(c1); port_c_2 = 3'(c2);
    port_errorFlag_0 = f0; port_errorFlag_1 = f1; port_errorFlag_2 = f2;
    clear_alarm = clr;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  // Pull reset low between edges, check outputs cleared without a clock, release later.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_q", 32'({port_q_0, port_q_1, port_q_2}), 0);
    chk("rst_alarm", 32'({alarm, locked, overflow}), 0);
    chk("rst_fault_cnt", 32'(fault_cnt), 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    #13;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_alarm", 32'(alarm), 0);
    chk("reset_fault_cnt", 32'(fault_cnt), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Clean stream 7/0/7 for three beats
    drive(1, 7, 0, 7, 1, 1, 1, 0, 1);
    tick();
    chk("clean_valid", 32'(out_valid), 1);
    chk("clean_q", 32'({port_q_0, port_q_1, port_q_2}), 32'({3'd7, 3'd0, 3'd7}));
    tick();
    tick();
    chk("clean_alarm_cnt", 32'({alarm, fault_cnt}), 0);

    // Single fault on share 1
    drive(1, 7, 0, 7, 1, 0, 1, 0, 1);
    tick();
    chk("fault_valid", 32'(out_valid), 0);
    chk("fault_q", 32'({port_q_0, port_q_1, port_q_2}), 0);
    chk("fault_alarm", 32'(alarm), 1);
    chk("fault_cnt1", 32'(fault_cnt), 1);
    drive(1, 3, 3, 3, 1, 1, 1, 0, 1);
    tick();
    chk("alarm_blocks", 32'(out_valid), 0);
    drive(1, 3, 3, 3, 1, 1, 1, 1, 1);
    tick();
    chk("cleared_alarm", 32'(alarm), 0);
    chk("clear_beat_dropped", 32'(out_valid), 0);
    drive(1, 5, 2, 3, 1, 1, 1, 0, 1);
    tick();
    chk("post_clear_valid", 32'(out_valid), 1);
    chk("post_clear_q", 32'({port_q_0, port_q_1, port_q_2}), 32'({3'd5, 3'd2, 3'd3}));

    // Clear colliding with a fault
    drive(1, 1, 1, 1, 0, 1, 1, 0, 1);
    tick();
    chk("fault2_cnt", 32'(fault_cnt), 2);
    drive(1, 1, 1, 1, 1, 1, 0, 1, 1);
    tick();
    chk("clear_fault_alarm", 32'(alarm), 1);
    chk("clear_fault_cnt", 32'(fault_cnt), 3);
    chk("clear_fault_notlocked", 32'(locked), 0);

    // Lockout on the 4th fault
    drive(0, 0, 0, 0, 1, 1, 1, 1, 1);
    tick();
    chk("rerun_alarm", 32'(alarm), 0);
    drive(1, 6, 6, 6, 0, 0, 0, 0, 1);
    tick();
    chk("locked4", 32'(locked), 1);
    chk("locked4_cnt", 32'(fault_cnt), 4);
    drive(1, 6, 6, 6, 1, 1, 1, 1, 1);
    tick();
    chk("locked_ignores_clear", 32'({alarm, locked}), 32'(2'b11));
    chk("locked_valid", 32'(out_valid), 0);
    async_reset();
    chk("unlocked_cnt", 32'(fault_cnt), 0);

    // Backpressure: second beat dropped while first is held
    drive(1, 1, 2, 3, 1, 1, 1, 0, 0);
    tick();
    chk("bp_first", 32'({port_q_0, port_q_1, port_q_2}), 32'({3'd1, 3'd2, 3'd3}));
    drive(1, 4, 5, 6, 1, 1, 1, 0, 0);
    tick();
    chk("bp_overflow", 32'(overflow), 1);
    chk("bp_keep_q", 32'({port_q_0, port_q_1, port_q_2}), 32'({3'd1, 3'd2, 3'd3}));
    chk("bp_still_valid", 32'(out_valid), 1);
    drive(0, 0, 0, 0, 1, 1, 1, 0, 1);
    tick();
    chk("bp_popped", 32'(out_valid), 0);
    chk("bp_q_hold", 32'(port_q_0), 1);

    // Async reset while a beat is pending
    drive(1, 7, 7, 7, 1, 1, 1, 0, 0);
    tick();
    chk("pre_reset_valid", 32'(out_valid), 1);
    async_reset();

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 149) == 0) async_reset();
      else tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
